// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared encodings, FSM states and write-mask helper for the data-memory bridge
package mem_bridge_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP,
    ERR
  } state_t;

  // Byte-lane write mask for an aligned access; illegal sizes get no lanes.
  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  lane_we = 4'b0001 << addr_lo;
      SIZE_H:  lane_we = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// rtl/load_extender.sv - little-endian lane select with sign/zero extension of RAM read data
module load_extender
  import mem_bridge_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      SIZE_B:  o_data = {{24{i_sign & w_byte[7]}}, w_byte};
      SIZE_H:  o_data = {{16{i_sign & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - single-outstanding load/store bridge from core memory stage to block RAM
module data_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_cnt;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [31:0] r_resp_rdata;
  logic        w_accept;
  logic        w_misalign;
  logic [31:0] w_ext;
  logic [31:0] w_rep_wdata;

  assign req_ready  = (r_state == IDLE) & ~rst;
  assign stall      = req_valid & ~req_ready;
  assign w_accept   = req_valid & req_ready;
  assign w_misalign = (req_size == SIZE_H && req_addr[0])
                    | (req_size == SIZE_W && req_addr[1:0] != 2'b00)
                    | (req_size == 2'b11);

  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign resp_rdata = r_resp_rdata;

  always_comb begin
    case (req_size)
      SIZE_B:  w_rep_wdata = {4{req_wdata[7:0]}};
      SIZE_H:  w_rep_wdata = {2{req_wdata[15:0]}};
      default: w_rep_wdata = req_wdata;
    endcase
  end

  load_extender u_ext (
    .i_rdata   (ram_rdata),
    .i_size    (r_size),
    .i_addr_lo (r_addr_lo),
    .i_sign    (r_sign),
    .o_data    (w_ext)
  );

  always_ff @(posedge clka or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    resp_valid = 1'b0;
    addr_err   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_misalign ? ERR : ACCESS;
      end
      ACCESS: begin
        ram_en = 1'b1;
        if (r_we) begin
          ram_we     = lane_we(r_size, r_addr_lo);
          resp_valid = 1'b1;
          w_next     = IDLE;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 3'd1) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        addr_err   = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // RAM address/data are only refreshed for good requests so an error never disturbs the RAM pins.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_sign       <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_cnt        <= 3'd0;
      r_ram_addr   <= 32'd0;
      r_ram_wdata  <= 32'd0;
      r_resp_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we      <= req_we;
        r_size    <= req_size;
        r_sign    <= req_sign;
        r_addr_lo <= req_addr[1:0];
        if (!w_misalign) begin
          r_ram_addr  <= {req_addr[31:2], 2'b00};
          r_ram_wdata <= w_rep_wdata;
        end
      end

      if (r_state == ACCESS && !r_we) r_cnt <= 3'(WAIT_CYCLES);
      else if (r_state == WAIT)       r_cnt <= r_cnt - 3'd1;

      r_resp_rdata <= (r_state == WAIT && r_cnt == 3'd1) ? w_ext : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - directed self-checking bench for data_mem_bridge with WAIT_CYCLES=2
module tb_data_mem_bridge;

  logic        clka = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  data_mem_bridge #(.WAIT_CYCLES(2)) dut (
    .clka       (clka),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .addr_err   (addr_err),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h1234_5678;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] exp);
    int n;
    issue(1'b0, size, sign, addr, 32'h0);
    cycle();
    idle_req();
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd1);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    n = 1;
    while (!resp_valid && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, 32'(addr_err), 32'd0);
    cycle();
  endtask

  initial begin
    idle_req();
    ram_rdata = 32'h80FF_7F01;
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    @(negedge clka);

    // word store
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    #1;
    chk("sw_stall_idle", 32'(stall), 32'd0);
    cycle();
    idle_req();
    chk("sw_ram_en", 32'(ram_en), 32'd1);
    chk("sw_ram_we", 32'(ram_we), 32'hF);
    chk("sw_ram_addr", ram_addr, 32'h10);
    chk("sw_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("sw_resp_valid", 32'(resp_valid), 32'd1);
    chk("sw_resp_rdata", resp_rdata, 32'd0);
    chk("sw_ready_busy", 32'(req_ready), 32'd0);
    cycle();
    chk("sw_after_valid", 32'(resp_valid), 32'd0);
    chk("sw_after_en", 32'(ram_en), 32'd0);
    chk("sw_after_we", 32'(ram_we), 32'd0);
    chk("sw_addr_hold", ram_addr, 32'h10);
    chk("sw_ready_back", 32'(req_ready), 32'd1);

    // byte store
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5);
    cycle();
    idle_req();
    chk("sb_ram_we", 32'(ram_we), 32'h8);
    chk("sb_ram_wdata", ram_wdata, 32'hA5A5_A5A5);
    chk("sb_ram_addr", ram_addr, 32'h10);
    chk("sb_resp_valid", 32'(resp_valid), 32'd1);
    cycle();

    // half store upper lanes
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF);
    cycle();
    idle_req();
    chk("sh_ram_we", 32'(ram_we), 32'hC);
    chk("sh_ram_wdata", ram_wdata, 32'hBEEF_BEEF);
    cycle();

    // loads against ram_rdata = 80FF_7F01
    do_load("lb_s_1", 2'b00, 1'b1, 32'h1, 32'h0000_007F);
    do_load("lh_s_2", 2'b01, 1'b1, 32'h2, 32'hFFFF_80FF);
    do_load("lh_u_2", 2'b01, 1'b0, 32'h2, 32'h0000_80FF);
    do_load("lb_s_3", 2'b00, 1'b1, 32'h3, 32'hFFFF_FF80);
    do_load("lb_u_3", 2'b00, 1'b0, 32'h3, 32'h0000_0080);
    do_load("lw_4", 2'b10, 1'b1, 32'h4, 32'h80FF_7F01);

    // misaligned word load
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    cycle();
    idle_req();
    chk("mis_resp_valid", 32'(resp_valid), 32'd1);
    chk("mis_addr_err", 32'(addr_err), 32'd1);
    chk("mis_ram_en", 32'(ram_en), 32'd0);
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_addr_hold", ram_addr, 32'h4);
    cycle();
    chk("mis_after_valid", 32'(resp_valid), 32'd0);
    chk("mis_after_en", 32'(ram_en), 32'd0);

    // illegal size and misaligned half
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    cycle();
    idle_req();
    chk("ill_err", 32'(addr_err), 32'd1);
    chk("ill_ram_we", 32'(ram_we), 32'd0);
    cycle();
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
    cycle();
    idle_req();
    chk("mish_err", 32'(addr_err), 32'd1);
    chk("mish_ram_en", 32'(ram_en), 32'd0);
    cycle();

    // back-to-back word loads with req_valid held
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
    cycle();
    chk("b2b_c1_stall", 32'(stall), 32'd1);
    chk("b2b_c1_en", 32'(ram_en), 32'd1);
    cycle();
    chk("b2b_c2_stall", 32'(stall), 32'd1);
    cycle();
    chk("b2b_c3_stall", 32'(stall), 32'd1);
    cycle();
    chk("b2b_c4_valid", 32'(resp_valid), 32'd1);
    chk("b2b_c4_stall", 32'(stall), 32'd1);
    cycle();
    chk("b2b_c5_stall", 32'(stall), 32'd0);
    chk("b2b_c5_ready", 32'(req_ready), 32'd1);
    chk("b2b_c5_valid", 32'(resp_valid), 32'd0);
    cycle();
    idle_req();
    chk("b2b_c6_en", 32'(ram_en), 32'd1);
    chk("b2b_c6_addr", ram_addr, 32'h8);
    cycle();
    cycle();
    cycle();
    chk("b2b_second_valid", 32'(resp_valid), 32'd1);
    chk("b2b_second_rdata", resp_rdata, 32'h80FF_7F01);
    cycle();

    // reset during WAIT
    issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    cycle();
    idle_req();
    cycle();
    rst = 1'b1;
    #1;
    chk("rstw_valid", 32'(resp_valid), 32'd0);
    chk("rstw_en", 32'(ram_en), 32'd0);
    chk("rstw_we", 32'(ram_we), 32'd0);
    chk("rstw_rdata", resp_rdata, 32'd0);
    chk("rstw_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rstw_hold_valid", 32'(resp_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rstw_release_ready", 32'(req_ready), 32'd1);
    @(negedge clka);
    do_load("post_rst_lh", 2'b01, 1'b0, 32'h0, 32'h0000_7F01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
